// File: rtl/uart_pkg.sv
// Shared UART frame-format constants and receiver state encoding.
// The transmitter uses the same frame-format constants.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int OVS       = 16;
  localparam int SMP_LO    = 7;
  localparam int SMP_MID   = 8;
  localparam int SMP_HI    = 9;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial pin plus user-side result signals of the UART receiver.
interface uart_rx_os_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_done;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output data_out, rx_done, frame_err, busy);
  modport slave  (output rx, input data_out, rx_done, frame_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-clock tick every DIV clocks, held at zero by clr.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be >= 2");
  end

  logic [W-1:0] div_cnt_q, div_cnt_d;

  assign tick = (div_cnt_q == W'(DIV - 1));

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (clr || tick) div_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end
endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority per bit, start-glitch
// rejection and framing-error pulse. Returns to IDLE at mid-stop.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  uart_rx_os_if.master bus
);
  localparam int DIV   = CLK_FREQ / (BAUD * OVS);
  localparam int OS_W  = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_BITS);

  logic                 rx_m_q, rx_s_q, rx_d_q;
  rx_state_e            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic [2:0]           smp_q, smp_d;
  logic                 dec_vld_q, dec_vld_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 tick, fall, dec_bit;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  assign fall    = rx_d_q & ~rx_s_q;
  assign dec_bit = maj3(smp_q[0], smp_q[1], smp_q[2]);

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_out_d  = data_out_q;
    smp_d       = smp_q;
    dec_vld_d   = 1'b0;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    // Samples land on the ticks that advance os_cnt to 7/8/9; the decision
    // is consumed one clock later via dec_vld_q.
    if (state_q != IDLE && tick) begin
      os_cnt_d = os_cnt_q + 1'b1;
      if (os_cnt_d == OS_W'(SMP_LO))  smp_d[0] = rx_s_q;
      if (os_cnt_d == OS_W'(SMP_MID)) smp_d[1] = rx_s_q;
      if (os_cnt_d == OS_W'(SMP_HI)) begin
        smp_d[2]  = rx_s_q;
        dec_vld_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (fall) state_d = START;
      end
      START: if (dec_vld_q) begin
        if (!dec_bit) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end else begin
          state_d   = IDLE;
        end
      end
      DATA: if (dec_vld_q) begin
        shreg_d[bit_idx_q] = dec_bit;
        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) state_d = STOP;
        else                                    bit_idx_d = bit_idx_q + 1'b1;
      end
      STOP: if (dec_vld_q) begin
        if (dec_bit) begin
          data_out_d = shreg_q;
          rx_done_d  = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_out_q  <= '0;
      smp_q       <= '0;
      dec_vld_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_m_q      <= bus.rx;
      rx_s_q      <= rx_m_q;
      rx_d_q      <= rx_s_q;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      smp_q       <= smp_d;
      dec_vld_q   <= dec_vld_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, idle-high line.
- It is the receive counterpart of the existing UART transmitter.
- 16x oversampling with 3-sample majority vote, start-bit glitch rejection and framing-error detection.
- Sits between the external RS-232 RX pin and the user logic; generates its own baud timing from clk.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DIV (localparam), CLK_FREQ/(BAUD*16) = 325: clocks per oversample tick, truncated. Must be >= 2; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line from the pin; asynchronous to clk.
- data_out  output  8  last correctly framed byte; held until the next good frame.
- rx_done  output  1  one-cycle pulse: data_out has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; data_out unchanged.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=8'h00, rx_done=0, frame_err=0, busy=0.
  - State=IDLE; all counters cleared.
  - Synchronizer flops set to 1 (line idle).
  - Reset mid-frame abandons the frame silently: no pulse, and data_out returns to 0.
- Input synchronisation:
  - rx passes through 2 flops to give rx_s, plus one more flop rx_d.
  - Falling edge = rx_d=1 && rx_s=0.
- Tick generator:
  - div_cnt counts 0..DIV-1; tick=1 for one clk when div_cnt==DIV-1.
  - div_cnt is held at 0 in IDLE and restarts from 0 on the detected falling edge.
  - os_cnt (4 bits) increments on each tick and wraps 15->0. A wrap marks a bit boundary.
- Sampling:
  - rx_s is captured on ticks where os_cnt = 7, 8 and 9.
  - Bit value = majority (at least 2 of 3).
  - The decision is registered on the clk after the os_cnt=9 tick.
- States:
  - IDLE: busy=0. On a falling edge go to START, with os_cnt=0 and div_cnt=0.
  - START: at the decision, majority 0 -> DATA with bit_idx=0. Majority 1 -> IDLE (glitch reject, no pulse).
  - DATA: at each decision, shift the majority bit into shreg[bit_idx], LSB first. After bit_idx 7 -> STOP; otherwise bit_idx+1.
  - STOP, decision majority 1: data_out<=shreg and rx_done=1 on the same edge; then IDLE.
  - STOP, decision majority 0: frame_err=1 and data_out is held; then IDLE.
- Return to IDLE at mid-stop:
  - IDLE is re-entered at the middle of the stop bit, so back-to-back frames with zero idle gap are received.
  - A line held low (break) does not retrigger, because IDLE needs a 1->0 edge.
- Latency:
  - rx_done rises (9*16+9)*DIV + 4 +/-1 clk after the rx pin falls.
  - Breakdown: 2-flop synchronizer, 1 edge-detect flop, 1 decision register.
  - At the defaults this is 153*325 + 4 = 49729 clk.
- Pulses: rx_done and frame_err are exactly one clk wide, mutually exclusive, and never both high.
- Tolerance: a frame must decode correctly with a transmitter baud error of up to +/-3%.

Decomposition:
- Shared package uart_pkg:
  - constants DATA_BITS=8 and OVS=16;
  - sample-point constants SMP_LO=7, SMP_MID=8, SMP_HI=9;
  - state enum {IDLE, START, DATA, STOP}. The transmitter also uses the frame-format constants.
- Sub-module uart_baud_tick (parameter DIV):
  - inputs clk, rst_n, clr; output tick.
  - One instance here; it is reusable as the transmitter's bit-clock generator with DIV = CLK_FREQ/BAUD.

Test Plan:
- Reset then idle: hold rx=1 for 10 frame times -> busy=0, rx_done and frame_err never assert, data_out=8'h00.
- Single frame: send 8'h55 at 9600 baud -> exactly one rx_done pulse, data_out=8'h55, rx_done rising 49729+/-1 clk after the start edge.
- Back-to-back frames: 8'h00, 8'hFF, 8'hA3 with zero idle gap -> three rx_done pulses with data_out 00, FF, A3 in order.
- Start glitch and noise:
  - A 3-tick (975 clk) low pulse on idle rx -> no pulse, busy returns to 0 within 10*DIV clk.
  - Then 8'h3C with a 1-tick inverted glitch at os_cnt=8 of bit 2 -> data_out=8'h3C.
- Framing error: send good 8'h12, then 8'hA3 with the stop bit driven 0 and held low for 3 bit times -> one frame_err pulse, data_out stays 8'h12, no retrigger. The next good 8'h7E is received.
- Baud tolerance plus reset mid-frame:
  - 8'hC5 at 9600*1.03 and at 9600*0.97 -> both received correctly.
  - rst_n pulsed low during bit 4 -> no pulse, data_out=8'h00. The following 8'h81 is received.
